// File: rtl/uart_rx_fifo.sv
// 8N1 oversampling UART receiver feeding a first-word-fall-through byte FIFO.
// Bytes leave on a valid/ready stream; uart_rtsn throttles the host bridge.
module uart_rx_fifo #(
  parameter int CLK_FREQ      = 100000000,
  parameter int BAUD          = 115200,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                          clk_100mhz,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  output logic                          uart_rtsn,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SPB = BAUD * OVERSAMPLE;
  localparam int DIV = (CLK_FREQ + SPB / 2) / SPB;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_m, rx_s;
  logic [DW-1:0] dcnt;
  logic          tick;

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shift, shift_n;
  logic          armed, armed_n;
  logic          push_req, ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count_n;
  logic          full, push, pop;

  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rxd;
      rx_s <= rx_m;
    end
  end

  assign tick = (dcnt == DW'(DIV - 1));

  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) dcnt <= '0;
    else         dcnt <= tick ? '0 : dcnt + 1'b1;
  end

  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
      armed <= 1'b1;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
      armed <= armed_n;
    end
  end

  // armed drops on a bad stop bit so a held-low line cannot restart a frame
  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bcnt_n   = bcnt;
    shift_n  = shift;
    armed_n  = armed;
    push_req = 1'b0;
    ferr     = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (rx_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            tcnt_n  = '0;
            state_n = START;
          end
        end
        START: begin
          if (tcnt == T_HALF) begin
            tcnt_n  = '0;
            bcnt_n  = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        DATA: begin
          if (tcnt == T_LAST) begin
            tcnt_n        = '0;
            shift_n[bcnt] = rx_s;
            bcnt_n        = bcnt + 3'd1;
            if (bcnt == 3'd7) state_n = STOP;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        STOP: begin
          if (tcnt == T_LAST) begin
            state_n = IDLE;
            tcnt_n  = '0;
            if (rx_s) begin
              push_req = 1'b1;
            end else begin
              ferr    = 1'b1;
              armed_n = 1'b0;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? mem[rptr] : 8'h00;
  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign pop     = m_valid && m_ready;
  assign push    = push_req && (!full || pop);
  assign count_n = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_100mhz) begin
    if (push) mem[wptr] <= shift;
  end

  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      uart_rtsn  <= 1'b1;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fifo_count <= count_n;
      uart_rtsn  <= (count_n >= CW'(RTS_THRESHOLD));
      frame_err  <= ferr;
      overrun    <= push_req && !push;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes,
// a negedge monitor pops and compares on every stream handshake.
module tb_uart_rx_fifo;

  localparam int OS       = 16;
  localparam int DIV      = 4;
  localparam int BAUD     = 115200;
  localparam int CLK_FREQ = BAUD * OS * DIV;
  localparam int BIT      = OS * DIV;
  localparam int DEPTH    = 16;
  localparam int THR      = 12;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       m_ready = 1'b0;
  logic       uart_rtsn, m_valid, frame_err, overrun;
  logic [7:0] m_data;
  logic [4:0] fifo_count;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  int cyc = 0;
  int rise_cyc = -1;
  int ferr_cnt = 0, ovr_cnt = 0, hs_cnt = 0, vld_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_rst = 1'b0;
  int lat, t0, f0, o0, h0, v0;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(OS),
    .FIFO_DEPTH(DEPTH),
    .RTS_THRESHOLD(THR)
  ) dut (
    .clk_100mhz(clk),
    .resetn(resetn),
    .uart_rxd(uart_rxd),
    .uart_rtsn(uart_rtsn),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_count(fifo_count),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_rtsn", int'(uart_rtsn), 1);
    end else begin
      if (prev_rst) chk("rtsn_level", int'(uart_rtsn), int'(fifo_count >= THR));
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (m_valid) vld_cnt++;
      if (m_valid && !prev_valid) rise_cyc = cyc;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("unexpected_byte", int'(m_data), -1);
        else chk("rx_byte", int'(m_data), int'(exp_q.pop_front()));
      end
    end
    prev_valid = m_valid;
    prev_rst   = resetn;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clks(BIT);
    end
    uart_rxd = stop_bit;
    wait_clks(BIT);
    uart_rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic align();
    while (cyc % DIV != 0) wait_clks(1);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    wait_clks(40);
    m_ready = 1'b0;
    wait_clks(1);
  endtask

  task automatic snap();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    h0 = hs_cnt;
    v0 = vld_cnt;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_data", int'(m_data), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    wait_clks(2);
    resetn = 1'b1;
    wait_clks(1);
    @(negedge clk);
    chk("rtsn_after_release", int'(uart_rtsn), 0);
    wait_clks(4);

    // single frame, also measures frame-start to m_valid latency
    m_ready = 1'b1;
    align();
    t0 = cyc;
    snap();
    send_good(8'hA5);
    wait_clks(BIT);
    @(negedge clk);
    lat = rise_cyc - t0;
    chk("t1_handshakes", hs_cnt - h0, 1);
    chk("t1_valid_cycles", vld_cnt - v0, 1);
    chk("t1_ferr", ferr_cnt - f0, 0);
    chk("t1_ovr", ovr_cnt - o0, 0);
    chk("t1_pending", exp_q.size(), 0);

    // burst of 12 with backpressure
    m_ready = 1'b0;
    wait_clks(1);
    for (int i = 0; i < 11; i++) send_good(8'(i));
    wait_clks(2);
    @(negedge clk);
    chk("t2_count11", int'(fifo_count), 11);
    chk("t2_rtsn11", int'(uart_rtsn), 0);
    wait_clks(1);
    send_good(8'h0B);
    wait_clks(2);
    @(negedge clk);
    chk("t2_count12", int'(fifo_count), 12);
    chk("t2_rtsn12", int'(uart_rtsn), 1);
    wait_clks(1);
    m_ready = 1'b1;
    wait_clks(1);
    m_ready = 1'b0;
    @(negedge clk);
    chk("t2_count_pop1", int'(fifo_count), 11);
    chk("t2_rtsn_pop1", int'(uart_rtsn), 0);
    wait_clks(1);
    drain();
    chk("t2_drained", int'(fifo_count), 0);
    chk("t2_pending", exp_q.size(), 0);

    // overrun on the 17th byte
    snap();
    for (int i = 1; i <= 16; i++) send_good(8'(8'h10 + i));
    send_frame(8'hC3, 1'b1);
    wait_clks(4);
    @(negedge clk);
    chk("t3_count", int'(fifo_count), 16);
    chk("t3_ovr", ovr_cnt - o0, 1);
    chk("t3_ferr", ferr_cnt - f0, 0);
    wait_clks(1);
    drain();
    chk("t3_pending", exp_q.size(), 0);

    // framing error then a good byte
    snap();
    send_frame(8'h3C, 1'b0);
    wait_clks(BIT);
    @(negedge clk);
    chk("t4_ferr", ferr_cnt - f0, 1);
    chk("t4_count", int'(fifo_count), 0);
    wait_clks(1);
    send_good(8'h55);
    wait_clks(4);
    @(negedge clk);
    chk("t4_count_good", int'(fifo_count), 1);
    chk("t4_ferr_good", ferr_cnt - f0, 1);
    wait_clks(1);
    drain();
    chk("t4_pending", exp_q.size(), 0);

    // break: one error, then wait for idle before a new frame
    snap();
    uart_rxd = 1'b0;
    wait_clks(BIT * 12);
    uart_rxd = 1'b1;
    wait_clks(BIT * 2);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_count", int'(fifo_count), 0);
    m_ready = 1'b1;
    send_good(8'h5A);
    wait_clks(8);
    m_ready = 1'b0;
    chk("brk_ferr_after", ferr_cnt - f0, 1);
    chk("brk_pending", exp_q.size(), 0);

    // short glitch on an idle line
    snap();
    uart_rxd = 1'b0;
    wait_clks(12);
    uart_rxd = 1'b1;
    wait_clks(BIT * 2);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_hs", hs_cnt - h0, 0);
    chk("glitch_count", int'(fifo_count), 0);

    // full FIFO, pop lands on the push cycle
    for (int i = 0; i < 16; i++) send_good(8'(8'h40 + i));
    wait_clks(4);
    @(negedge clk);
    chk("t5_full", int'(fifo_count), 16);
    wait_clks(1);
    snap();
    align();
    fork
      send_good(8'h77);
      begin
        wait_clks(lat - 1);
        m_ready = 1'b1;
        wait_clks(1);
        m_ready = 1'b0;
      end
    join
    wait_clks(4);
    @(negedge clk);
    chk("t5_count", int'(fifo_count), 16);
    chk("t5_ovr", ovr_cnt - o0, 0);
    chk("t5_hs", hs_cnt - h0, 1);
    wait_clks(1);
    drain();
    chk("t5_pending", exp_q.size(), 0);

    // reset during data bit 4
    send_good(8'h21);
    send_good(8'h22);
    wait_clks(2);
    uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = 1'(i % 2);
      wait_clks(BIT);
    end
    uart_rxd = 1'b0;
    wait_clks(BIT / 2);
    resetn = 1'b0;
    exp_q.delete();
    wait_clks(10);
    @(negedge clk);
    chk("t6_rst_count", int'(fifo_count), 0);
    uart_rxd = 1'b1;
    wait_clks(BIT);
    resetn = 1'b1;
    wait_clks(BIT * 2);
    snap();
    m_ready = 1'b1;
    send_good(8'h81);
    wait_clks(8);
    m_ready = 1'b0;
    @(negedge clk);
    chk("t6_hs", hs_cnt - h0, 1);
    chk("t6_pending", exp_q.size(), 0);
    chk("t6_ferr", ferr_cnt - f0, 0);
    chk("t6_ovr", ovr_cnt - o0, 0);
    chk("t6_count", int'(fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
